vram_arbiter: RTL and testbench

//  Shares the 16-bit word port of the dual-port video RAM between the CPU bus and the video

---
 rtl/vram_arbiter.sv | 128 ++++++++++++
 tb/tb_vram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Purpose: shares the single VRAM word port between the CPU bus and the video fetcher, video first with a CPU burst limit.
// Latency: CPU grant to cpu_ack is 2 edges; a video push reaches vid_valid after at least 3 edges.
// Backpressure: cpu_req is held until cpu_ack; video requests arriving at a full FIFO are dropped and flagged in vid_ovf.
module vram_arbiter #(
    parameter int AW            = 10,
    parameter int DW            = 16,
    parameter int VQ_DEPTH      = 2,
    parameter int MAX_VID_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_sel,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ovf,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic [1:0]    ram_sel,
    input  logic [DW-1:0] ram_dout
);
    localparam int PW = $clog2(VQ_DEPTH);
    localparam int BW = $clog2(MAX_VID_BURST + 1);
    localparam logic [PW:0]   VQ_FULL   = (PW + 1)'(VQ_DEPTH);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_VID_BURST);

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_VID, SLOT_CPU} slot_t;

    logic [AW-1:0] vq_mem [VQ_DEPTH];
    logic [PW-1:0] vq_rd_ptr, vq_wr_ptr;
    logic [PW:0]   vq_cnt;
    logic          vq_empty, vq_full, vq_push, vq_pop;
    logic          cpu_pend, cpu_elig;
    logic [BW-1:0] burst_cnt;
    logic          grant_vid, grant_cpu;
    slot_t         slot0, slot1;
    logic          slot1_we;

    assign vq_empty = (vq_cnt == '0);
    assign vq_full  = (vq_cnt == VQ_FULL);
    assign cpu_elig = cpu_req & ~cpu_pend & ~cpu_ack;

    // The burst limit overrides video priority once the CPU has waited long enough.
    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (cpu_elig && burst_cnt == BURST_MAX) begin
            grant_cpu = 1'b1;
        end else if (!vq_empty) begin
            grant_vid = 1'b1;
        end else if (cpu_elig) begin
            grant_cpu = 1'b1;
        end
    end

    assign vq_pop  = grant_vid;
    assign vq_push = vid_req & (~vq_full | vq_pop);

    always_ff @(posedge clk) begin
        if (vq_push) vq_mem[vq_wr_ptr] <= vid_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq_rd_ptr <= '0;
            vq_wr_ptr <= '0;
            vq_cnt    <= '0;
            vid_ovf   <= 1'b0;
            burst_cnt <= '0;
            cpu_pend  <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            ram_sel   <= 2'b00;
            slot0     <= SLOT_IDLE;
            slot1     <= SLOT_IDLE;
            slot1_we  <= 1'b0;
            vid_valid <= 1'b0;
            vid_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (vq_push) vq_wr_ptr <= vq_wr_ptr + 1'b1;
            if (vq_pop)  vq_rd_ptr <= vq_rd_ptr + 1'b1;
            vq_cnt <= vq_cnt + {{PW{1'b0}}, vq_push} - {{PW{1'b0}}, vq_pop};
            if (vid_req && vq_full && !vq_pop) vid_ovf <= 1'b1;

            if (grant_cpu || !cpu_elig) begin
                burst_cnt <= '0;
            end else if (grant_vid && burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            if (grant_cpu) begin
                cpu_pend <= 1'b1;
            end else if (slot1 == SLOT_CPU) begin
                cpu_pend <= 1'b0;
            end

            // Access phase: address/data/strobes registered at the grant edge.
            ram_we  <= grant_cpu & cpu_we;
            ram_sel <= (grant_cpu && cpu_we) ? cpu_sel : 2'b00;
            if (grant_vid) begin
                ram_addr <= vq_mem[vq_rd_ptr];
            end else if (grant_cpu) begin
                ram_addr <= cpu_addr;
                ram_din  <= cpu_wdata;
            end
            slot0    <= grant_vid ? SLOT_VID : (grant_cpu ? SLOT_CPU : SLOT_IDLE);
            slot1    <= slot0;
            slot1_we <= ram_we;

            // Return phase: RAM read data is valid two edges after the grant.
            vid_valid <= (slot1 == SLOT_VID);
            if (slot1 == SLOT_VID) vid_rdata <= ram_dout;
            cpu_ack <= (slot1 == SLOT_CPU);
            if (slot1 == SLOT_CPU && !slot1_we) cpu_rdata <= ram_dout;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a behavioural RAM, a grant-order reference model feeding
// expected-result queues, and a monitor that pops them whenever the DUT acks or presents video data.
module tb_vram_arbiter;
    localparam int AW = 10, DW = 16, VQ_DEPTH = 2, MAX_VID_BURST = 4;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [1:0]    cpu_sel = 2'b00;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid, vid_ovf;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [1:0]    ram_sel;
    logic [DW-1:0] ram_dout = '0;

    vram_arbiter #(.AW(AW), .DW(DW), .VQ_DEPTH(VQ_DEPTH), .MAX_VID_BURST(MAX_VID_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_rdata(vid_rdata),
        .vid_ovf(vid_ovf), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_sel(ram_sel), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_pat(input logic [AW-1:0] a);
        logic [15:0] t;
        t = {6'b0, a};
        return (t * 16'h9E37) ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] sel);
        return {sel[1] ? nw[15:8] : old[15:8], sel[0] ? nw[7:0] : old[7:0]};
    endfunction

    // Behavioural video RAM: synchronous read, write-first.
    logic [DW-1:0] ram [1<<AW];
    bit            ram_wr [1<<AW];
    function automatic logic [15:0] ram_rd(input logic [AW-1:0] a);
        return ram_wr[a] ? ram[a] : init_pat(a);
    endfunction
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr]    <= merge(ram_rd(ram_addr), ram_din, ram_sel);
            ram_wr[ram_addr] <= 1'b1;
            ram_dout         <= merge(ram_rd(ram_addr), ram_din, ram_sel);
        end else begin
            ram_dout <= ram_rd(ram_addr);
        end
    end

    typedef struct {int e; logic [DW-1:0] d;} exp_t;
    exp_t          cpu_q[$], vid_q[$];
    logic [AW-1:0] mq[$];
    logic [DW-1:0] sh [1<<AW];
    bit            sh_wr [1<<AW];
    int  total = 0, bad = 0, edge_n = 0;
    int  m_last_cpu = -100, m_burst = 0;
    bit  m_ovf = 1'b0;
    logic [DW-1:0] m_last_rd = '0;
    int  pushes = 0, drops = 0, vid_seen = 0, ack_seen = 0;
    int  vid_left = 0;
    bit  vid_rnd = 1'b0;

    function automatic logic [15:0] sh_rd(input logic [AW-1:0] a);
        return sh_wr[a] ? sh[a] : init_pat(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Reference: one grant per edge from the arbitration rules, results queued with their due edge.
    task automatic model_step();
        bit elig, g_cpu, g_vid;
        int sz;
        exp_t x;
        logic [AW-1:0] a;
        elig  = cpu_req && (edge_n >= m_last_cpu + 4);
        sz    = mq.size();
        g_cpu = 1'b0;
        g_vid = 1'b0;
        if (elig && m_burst == MAX_VID_BURST) g_cpu = 1'b1;
        else if (sz > 0)                      g_vid = 1'b1;
        else if (elig)                        g_cpu = 1'b1;
        if (g_cpu || !elig) m_burst = 0;
        else if (m_burst < MAX_VID_BURST) m_burst++;
        if (g_vid) begin
            a = mq.pop_front();
            x.e = edge_n + 2;
            x.d = sh_rd(a);
            vid_q.push_back(x);
        end
        if (vid_req) begin
            pushes++;
            if (sz == VQ_DEPTH && !g_vid) begin
                drops++;
                m_ovf = 1'b1;
            end else begin
                mq.push_back(vid_addr);
            end
        end
        if (g_cpu) begin
            m_last_cpu = edge_n;
            x.e = edge_n + 2;
            if (cpu_we) begin
                sh[cpu_addr]    = merge(sh_rd(cpu_addr), cpu_wdata, cpu_sel);
                sh_wr[cpu_addr] = 1'b1;
                x.d = m_last_rd;
            end else begin
                x.d = sh_rd(cpu_addr);
                m_last_rd = x.d;
            end
            cpu_q.push_back(x);
        end
    endtask

    task automatic monitor_step();
        exp_t x;
        if (vid_valid) begin
            vid_seen++;
            if (vid_q.size() == 0) chk("vid_spurious", vid_valid, 0);
            else begin
                x = vid_q.pop_front();
                chk("vid_data", vid_rdata, x.d);
                chk("vid_edge", edge_n, x.e);
            end
        end else if (vid_q.size() > 0 && vid_q[0].e <= edge_n) begin
            x = vid_q.pop_front();
            chk("vid_missing", vid_valid, 1);
        end
        if (cpu_ack) begin
            ack_seen++;
            if (cpu_q.size() == 0) chk("cpu_spurious", cpu_ack, 0);
            else begin
                x = cpu_q.pop_front();
                chk("cpu_rdata", cpu_rdata, x.d);
                chk("cpu_edge", edge_n, x.e);
            end
        end else if (cpu_q.size() > 0 && cpu_q[0].e <= edge_n) begin
            x = cpu_q.pop_front();
            chk("cpu_missing", cpu_ack, 1);
        end
        chk("vid_ovf", vid_ovf, m_ovf);
    endtask

    task automatic do_reset(input bit rnd);
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        vid_rnd = 1'b1;
        vid_left = rnd ? 4 : 0;
        for (int i = 0; i < 4; i++) begin
            if (rnd) begin
                cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_sel = 2'($urandom);
                cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end
            @(posedge clk); #1;
            chk("rst_outputs", {cpu_ack, cpu_rdata, vid_valid, vid_rdata, vid_ovf,
                                ram_addr, ram_din, ram_we, ram_sel}, 64'd0);
            @(negedge clk);
        end
        cpu_req = 1'b0;
        vid_left = 0;
        rst_n = 1'b1;
    endtask

    task automatic cpu_op(input bit we, input logic [1:0] sel, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
        int start;
        bit got = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = a; cpu_wdata = d;
        start = edge_n;
        lat = -1;
        rd = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                got = 1'b1;
                lat = edge_n - start - 1;
                rd = cpu_rdata;
            end
        end
        if (!got) chk("cpu_timeout", cpu_ack, 1);
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_sel = 2'($urandom);
        cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    endtask

    task automatic rand_op(output int lat);
        logic [DW-1:0] rd;
        cpu_op(1'($urandom), 2'($urandom), AW'($urandom_range(0, 31)), DW'($urandom), lat, rd);
    endtask

    initial begin
        int lat, p0, d0, v0, s0;
        logic [DW-1:0] rd;
        fork
            forever begin
                @(posedge clk);
                edge_n++;
                if (!rst_n) begin
                    mq.delete(); cpu_q.delete(); vid_q.delete();
                    m_burst = 0; m_ovf = 1'b0; m_last_cpu = -100; m_last_rd = '0;
                end else begin
                    model_step();
                end
                #1;
                if (rst_n) monitor_step();
            end
            forever begin
                @(negedge clk);
                if (vid_left > 0) begin
                    vid_left--;
                    vid_req  = vid_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    vid_addr = AW'($urandom_range(0, 31));
                end else begin
                    vid_req = 1'b0;
                end
            end
        join_none

        // T1: reset with random inputs, then quiet
        do_reset(1'b1);
        s0 = vid_seen + ack_seen;
        repeat (4) @(negedge clk);
        chk("t1_idle", vid_seen + ack_seen - s0, 0);

        // T2: full write then read back
        cpu_op(1'b1, 2'b11, 10'h005, 16'h1234, lat, rd); chk("t2_wr_lat", lat, 2);
        cpu_op(1'b0, 2'b11, 10'h005, 16'h0000, lat, rd); chk("t2_rd_lat", lat, 2);
        chk("t2_rd", rd, 16'h1234);

        // T3: byte-lane writes, including an all-lanes-off write
        cpu_op(1'b1, 2'b01, 10'h005, 16'hABCD, lat, rd);
        cpu_op(1'b0, 2'b00, 10'h005, 16'h0000, lat, rd); chk("t3_lo", rd, 16'h12CD);
        cpu_op(1'b1, 2'b10, 10'h005, 16'h5600, lat, rd);
        cpu_op(1'b0, 2'b00, 10'h005, 16'h0000, lat, rd); chk("t3_hi", rd, 16'h56CD);
        cpu_op(1'b1, 2'b00, 10'h005, 16'hFFFF, lat, rd); chk("t3_sel0_lat", lat, 2);
        cpu_op(1'b0, 2'b00, 10'h005, 16'h0000, lat, rd); chk("t3_sel0", rd, 16'h56CD);

        // T4: saturated video; each CPU access waits exactly one full video burst
        vid_rnd = 1'b0; vid_left = 1000;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rand_op(lat);
            chk("t4_burst_lat", lat, 2 + MAX_VID_BURST);
        end
        vid_left = 0;
        repeat (8) @(negedge clk);

        // T5: 20 cycles of video against a busy CPU; overflow and conservation
        do_reset(1'b0);
        p0 = pushes; d0 = drops; v0 = vid_seen;
        vid_rnd = 1'b0; vid_left = 20;
        while (vid_left > 0) rand_op(lat);
        repeat (10) @(negedge clk);
        chk("t5_count", vid_seen - v0, (pushes - p0) - (drops - d0));
        chk("t5_ovf", vid_ovf, 1);

        // T6: reset with a full FIFO and a CPU read in flight
        vid_rnd = 1'b0; vid_left = 1000;
        repeat (4) @(negedge clk);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_last_cpu == edge_n) break;
        end
        do_reset(1'b0);
        chk("t6_ovf", vid_ovf, 0);
        s0 = vid_seen + ack_seen;
        repeat (6) @(negedge clk);
        chk("t6_quiet", vid_seen + ack_seen - s0, 0);
        cpu_op(1'b0, 2'b00, 10'h005, 16'h0000, lat, rd);
        chk("t6_rd_lat", lat, 2);
        chk("t6_rd", rd, 16'h56CD);

        // Random mix of sparse video and CPU traffic
        vid_rnd = 1'b1; vid_left = 600;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rand_op(lat);
            chk("rand_lat_bound", (lat >= 2 && lat <= 2 + MAX_VID_BURST), 1);
        end
        vid_left = 0;
        repeat (10) @(negedge clk);
        chk("end_cpu_q", cpu_q.size(), 0);
        chk("end_vid_q", vid_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
